// File: rtl/dl_ram_writer_pkg.sv
// ============================================================================
// Module : dl_ram_writer_pkg
// Brief  : Shared state encoding and default widths for the download RAM writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dl_ram_writer_pkg;

    localparam int C_AW           = 25;
    localparam int C_DW           = 16;
    localparam int C_IDX_W        = 5;
    localparam int C_FIFO_DEPTH   = 4;
    localparam int C_GUARD_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dl_wr_fifo.sv
// ============================================================================
// Module : dl_wr_fifo
// Brief  : Synchronous FIFO with pop-before-push on full and next-head lookahead.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dl_wr_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             push_ok,
    output logic             empty_nxt,
    output logic [WIDTH-1:0] head_nxt
);

    localparam int            PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   C_PTR_ONE   = (PW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [PW:0]      w_wr_nxt;
    logic [PW:0]      w_rd_nxt;
    logic             w_pop_ok;

    assign full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign w_pop_ok = pop && !empty;
    assign push_ok  = push && (!full || w_pop_ok);

    assign w_wr_nxt  = push_ok  ? r_wr_ptr + C_PTR_ONE : r_wr_ptr;
    assign w_rd_nxt  = w_pop_ok ? r_rd_ptr + C_PTR_ONE : r_rd_ptr;
    assign empty_nxt = (w_rd_nxt == w_wr_nxt);

    // If the FIFO drains to empty before this push, the new head is the word being written.
    assign head_nxt  = (push_ok && (w_rd_nxt == r_wr_ptr)) ? din : r_mem[w_rd_nxt[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            r_mem[r_wr_ptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dl_ram_writer.sv
// ============================================================================
// Module : dl_ram_writer
// Brief  : Buffers download word writes and replays them to SDRAM over req/ack.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dl_ram_writer
    import dl_ram_writer_pkg::*;
#(
    parameter int AW           = C_AW,
    parameter int DW           = C_DW,
    parameter int FIFO_DEPTH   = C_FIFO_DEPTH,
    parameter int GUARD_CYCLES = C_GUARD_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dl_downloading,
    input  logic [C_IDX_W-1:0] dl_index,
    input  logic               dl_wr,
    input  logic [AW-1:0]      dl_addr,
    input  logic [DW-1:0]      dl_data,
    output logic               ram_req,
    input  logic               ram_ack,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    output logic               cpu_hold,
    output logic               done,
    output logic [C_IDX_W-1:0] done_index,
    output logic [AW-1:0]      done_words,
    output logic               overflow
);

    localparam int             GW           = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0]  C_GUARD_INIT = GW'(GUARD_CYCLES);
    localparam logic [GW-1:0]  C_GUARD_ONE  = GW'(1);
    localparam logic [AW-1:0]  C_WORD_ONE   = AW'(1);

    logic [1:0]         r_sync;
    logic               r_dls_prev;
    logic               w_dls;
    logic               w_rise;
    logic               w_fall;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_guard_load;
    logic               w_accept_en;

    logic [GW-1:0]      r_guard;
    logic [AW-1:0]      r_words;
    logic [C_IDX_W-1:0] r_index;
    logic [C_IDX_W-1:0] r_done_index;
    logic [AW-1:0]      r_done_words;
    logic               r_overflow;

    logic               r_ram_req;
    logic [AW-1:0]      r_ram_addr;
    logic [DW-1:0]      r_ram_din;

    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_empty_nxt;
    logic [AW+DW-1:0]   w_head_nxt;

    assign w_dls      = r_sync[1];
    assign w_rise     = w_dls && !r_dls_prev;
    assign w_fall     = !w_dls && r_dls_prev;
    assign w_push_req = dl_wr && w_accept_en;
    assign w_pop      = r_ram_req && ram_ack;

    dl_wr_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push_req),
        .din       ({dl_addr, dl_data}),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .push_ok   (w_push_ok),
        .empty_nxt (w_empty_nxt),
        .head_nxt  (w_head_nxt)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_guard_load = 1'b0;
        w_accept_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_LOAD;
                    w_start     = 1'b1;
                end
            end
            ST_LOAD: begin
                w_accept_en = 1'b1;
                if (w_fall) begin
                    w_state_nxt  = ST_FLUSH;
                    w_guard_load = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_accept_en = 1'b1;
                if (w_rise) begin
                    w_state_nxt = ST_LOAD;
                    w_start     = 1'b1;
                // A write in this very cycle would otherwise land after the done report.
                end else if ((r_guard == '0) && w_empty && !r_ram_req && !dl_wr) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= '0;
            r_dls_prev   <= 1'b0;
            r_state      <= ST_IDLE;
            r_guard      <= '0;
            r_words      <= '0;
            r_index      <= '0;
            r_done_index <= '0;
            r_done_words <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], dl_downloading};
            r_dls_prev <= w_dls;
            r_state    <= w_state_nxt;

            if (w_guard_load) begin
                r_guard <= C_GUARD_INIT;
            end else if (r_guard != '0) begin
                r_guard <= r_guard - C_GUARD_ONE;
            end

            if (w_start) begin
                r_words <= '0;
                r_index <= dl_index;
            end else if (w_push_ok && (r_words != '1)) begin
                r_words <= r_words + C_WORD_ONE;
            end

            if (w_start) begin
                r_overflow <= 1'b0;
            end else if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end

            if (w_state_nxt == ST_DONE) begin
                r_done_index <= r_index;
                r_done_words <= r_words;
            end
        end
    end

    // RAM port registers are loaded from the FIFO's next head so a push shows up one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_req  <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            r_ram_req <= !w_empty_nxt;
            if (!w_empty_nxt) begin
                {r_ram_addr, r_ram_din} <= w_head_nxt;
            end
        end
    end

    assign ram_req    = r_ram_req;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign cpu_hold   = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign done_index = r_done_index;
    assign done_words = r_done_words;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire
